// File: rtl/vga_sched_pkg.sv
// Shared types and widths for the vblank update scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  localparam int FRAME_CNT_W = 16;
  localparam int TO_CNT_W    = 12;

endpackage

// File: rtl/vblank_update_scheduler_frame_tick_gen.sv
// Frame-start detection from the registered vs, frame counter and the
// frames-per-game-tick divider.
module frame_tick_gen
  import vga_sched_pkg::*;
#(
  parameter int   TICK_DIV = 1,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vs_i,
  input  logic                   enable_i,
  output logic                   vs_start_o,
  output logic                   tick_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int              DIV_W    = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic                   vs_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  assign vs_start_o  = (vs_i == VS_POL) && (vs_q != VS_POL);
  assign tick_o      = vs_start_o && enable_i && (div_q == DIV_LAST);
  assign frame_cnt_o = frame_cnt_q;

  // The divider only moves on frame starts and is parked at 0 while disabled.
  always_comb begin
    div_d = div_q;
    if (vs_start_o) begin
      if (!enable_i || (div_q == DIV_LAST)) begin
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= ~VS_POL;
      div_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      vs_q  <= vs_i;
      div_q <= div_d;
      if (vs_start_o) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants each game-logic update unit one req/ack slot per game tick, in index
// order, during vertical blanking; flags timeouts, overruns and missed ticks.
module vblank_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int   N_UNITS  = 3,
  parameter int   TICK_DIV = 1,
  parameter int   TIMEOUT  = 4095,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vs_i,
  input  logic                   de_i,
  input  logic                   enable_i,
  input  logic                   err_clr_i,
  input  logic [N_UNITS-1:0]     upd_ack_i,
  output logic [N_UNITS-1:0]     upd_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [N_UNITS-1:0]     timeout_err_o,
  output logic                   overrun_o,
  output logic                   missed_o
);

  localparam int                 IDX_W    = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_UNITS - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TO_CNT_W-1:0]   to_q, to_d;
  logic [N_UNITS-1:0]    req_q, req_d;
  logic [N_UNITS-1:0]    to_err_q, to_err_d, to_set;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  missed_q, missed_d;
  logic                  busy, vs_start, tick, frame_tick;

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .VS_POL   (VS_POL)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .vs_i        (vs_i),
    .enable_i    (enable_i),
    .vs_start_o  (vs_start),
    .tick_o      (tick),
    .frame_cnt_o (frame_cnt_o)
  );

  assign frame_tick = vs_start && tick;
  assign busy       = (state_q != ST_IDLE);

  // Request vector is computed alongside the next state so it can be registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    to_d    = to_q;
    req_d   = '0;
    done_d  = 1'b0;
    to_set  = '0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_REQ;
          idx_d   = '0;
          to_d    = '0;
          req_d   = N_UNITS'(1);
        end
      end
      ST_REQ: begin
        if (upd_ack_i[idx_q]) begin
          state_d = ST_GAP;
          done_d  = (idx_q == LAST_IDX);
        end else if (to_q == TO_LAST) begin
          state_d       = ST_GAP;
          to_set[idx_q] = 1'b1;
          done_d        = (idx_q == LAST_IDX);
        end else begin
          to_d  = to_q + 1'b1;
          req_d = req_q;
        end
      end
      ST_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
          idx_d   = idx_q + 1'b1;
          to_d    = '0;
          req_d   = N_UNITS'(1) << (idx_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a new set in the same cycle as a clear takes priority.
  always_comb begin
    to_err_d  = (err_clr_i ? '0 : to_err_q) | to_set;
    overrun_d = (busy && de_i) || (overrun_q && !err_clr_i);
    missed_d  = (busy && frame_tick) || (missed_q && !err_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      to_q      <= '0;
      req_q     <= '0;
      done_q    <= 1'b0;
      to_err_q  <= '0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      req_q     <= req_d;
      done_q    <= done_d;
      to_err_q  <= to_err_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
    end
  end

  assign upd_req_o     = req_q;
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign timeout_err_o = to_err_q;
  assign overrun_o     = overrun_q;
  assign missed_o      = missed_q;

endmodule
